// File: rtl/bumpy_pkg.sv
// Shared definitions for the Bumpy game blocks: motion state encoding and
// the one-hot collision edge codes reported alongside each collision.
package bumpy_pkg;

  // Motion state shared with the motion/position block.
  typedef enum logic [3:0] {
    Sreset             = 4'd0,
    Sidle              = 4'd1,
    Sleft              = 4'd2,
    Sright             = 4'd3,
    Sdown              = 4'd4,
    Sup                = 4'd5,
    Sdie               = 4'd6,
    Sbounce_from_left  = 4'd7,
    Sbounce_from_right = 4'd8,
    Sbounce_from_top   = 4'd9,
    Sdown_from_right   = 4'd10,
    Sdown_from_left    = 4'd11
  } state_t;

  // One-hot edge codes on HitEdgeCode.
  localparam logic [3:0] BOTTOM = 4'b0001;
  localparam logic [3:0] RIGHT  = 4'b0010;
  localparam logic [3:0] TOP    = 4'b0100;
  localparam logic [3:0] LEFT   = 4'b1000;

  // Width of the per-state frame counter.
  localparam int TIMER_W = 5;

  // Codes 12..15 have no meaning and must be recovered from.
  function automatic logic is_legal(input state_t s);
    return (s <= Sdown_from_left);
  endfunction

endpackage

// File: rtl/bumpy_state_ctrl_if.sv
// Bundle between the game inputs (keys, collisions, frame tick) and the
// state controller, plus the state/lives/game_over results it publishes.
interface bumpy_state_ctrl_if;
  import bumpy_pkg::*;

  logic       startOfFrame;
  logic       game_start;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       step_collision;
  logic       free_collision;
  logic       border_collision;
  logic       death_collision;
  logic [3:0] HitEdgeCode;
  state_t     state;
  logic [1:0] lives;
  logic       game_over;

  // Side that produces keys, collisions and the frame tick.
  modport master (
    output startOfFrame, game_start,
    output key_left, key_right, key_up, key_down,
    output step_collision, free_collision, border_collision, death_collision,
    output HitEdgeCode,
    input  state, lives, game_over
  );

  // The state controller itself.
  modport slave (
    input  startOfFrame, game_start,
    input  key_left, key_right, key_up, key_down,
    input  step_collision, free_collision, border_collision, death_collision,
    input  HitEdgeCode,
    output state, lives, game_over
  );

endinterface

// File: rtl/bumpy_frame_timer.sv
// Counts frame pulses spent in the current state and flags the pulse that
// reaches the state's limit, so the transition lands on that pulse's edge.
module bumpy_frame_timer
  import bumpy_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               startOfFrame,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count_reg;

  // A zero limit means the current state has no timeout.
  assign expired = startOfFrame && (limit != '0) &&
                   (count_reg == limit - TIMER_W'(1));

  // Frame counter: clear wins so the pulse on the entry edge is not counted;
  // saturates so long stays in untimed states cannot wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (startOfFrame && (count_reg != '1)) begin
      count_reg <= count_reg + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/bumpy_state_ctrl.sv
// Bumpy game-control FSM: turns key edges, collisions and frame ticks into
// one registered motion state per cycle, and tracks lives and game-over.
module bumpy_state_ctrl
  import bumpy_pkg::*;
#(
  parameter int HOP_FRAMES    = 16,
  parameter int UP_FRAMES     = 10,
  parameter int BOUNCE_FRAMES = 8,
  parameter int DIE_FRAMES    = 30,
  parameter int INIT_LIVES    = 3
) (
  input  logic               clk,
  input  logic               resetN,
  bumpy_state_ctrl_if.slave  bus
);

  state_t             state_reg;
  state_t             state_next;
  logic [1:0]         lives_reg;
  logic [1:0]         lives_next;
  logic               game_over_reg;
  logic               game_over_next;
  logic               respawn_reg;
  logic               respawn_next;
  logic [3:0]         key_d_reg;
  logic [3:0]         keys;
  logic [3:0]         key_edge;
  logic               edge_valid;
  logic               hit_bottom;
  logic               hit_right;
  logic               hit_top;
  logic               hit_left;
  logic [TIMER_W-1:0] limit;
  logic               expired;
  logic               timer_clear;

  // Key vector order: bit0 left, bit1 right, bit2 up, bit3 down.
  assign keys       = {bus.key_down, bus.key_up, bus.key_right, bus.key_left};
  assign key_edge   = keys & ~key_d_reg;
  // Simultaneous edges are ambiguous, so only a lone edge is acted on.
  assign edge_valid = $onehot(key_edge);

  // Collisions only count when the edge bit their rule needs is reported.
  assign hit_bottom = |(bus.HitEdgeCode & BOTTOM);
  assign hit_right  = |(bus.HitEdgeCode & RIGHT);
  assign hit_top    = |(bus.HitEdgeCode & TOP);
  assign hit_left   = |(bus.HitEdgeCode & LEFT);

  assign bus.state     = state_reg;
  assign bus.lives     = lives_reg;
  assign bus.game_over = game_over_reg;

  // Any state change restarts the frame count for the new state.
  assign timer_clear = (state_next != state_reg);

  bumpy_frame_timer u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (timer_clear),
    .startOfFrame (bus.startOfFrame),
    .limit        (limit),
    .expired      (expired)
  );

  // Timeout length of the current state (zero = never times out).
  always_comb begin
    limit = '0;
    case (state_reg)
      Sleft, Sright:         limit = TIMER_W'(HOP_FRAMES);
      Sup:                   limit = TIMER_W'(UP_FRAMES);
      Sbounce_from_left,
      Sbounce_from_right,
      Sbounce_from_top:      limit = TIMER_W'(BOUNCE_FRAMES);
      Sdie:                  limit = TIMER_W'(DIE_FRAMES);
      default:               limit = '0;
    endcase
  end

  // Key history register for rising-edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_d_reg <= '0;
    end else begin
      key_d_reg <= keys;
    end
  end

  // State, lives, game-over and respawn registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= Sreset;
      lives_reg     <= 2'(INIT_LIVES);
      game_over_reg <= 1'b0;
      respawn_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      game_over_reg <= game_over_next;
      respawn_reg   <= respawn_next;
    end
  end

  // Next-state and life bookkeeping; death outranks every per-state rule and
  // collisions are tested before timer expiry so they win a same-cycle tie.
  always_comb begin
    state_next     = state_reg;
    lives_next     = lives_reg;
    game_over_next = game_over_reg;
    respawn_next   = respawn_reg;

    if (!is_legal(state_reg)) begin
      state_next = Sreset;
    end else if (bus.death_collision && (state_reg != Sreset) &&
                 (state_reg != Sdie)) begin
      state_next = Sdie;
    end else begin
      case (state_reg)
        Sreset: begin
          if (bus.game_start) begin
            state_next   = Sidle;
            respawn_next = 1'b0;
            if (game_over_reg) begin
              lives_next     = 2'(INIT_LIVES);
              game_over_next = 1'b0;
            end
          end else if (respawn_reg) begin
            // Lost a life but not the game: resume without game_start.
            state_next   = Sidle;
            respawn_next = 1'b0;
          end
        end

        Sidle: begin
          if (edge_valid) begin
            if (key_edge[0])      state_next = Sleft;
            else if (key_edge[1]) state_next = Sright;
            else if (key_edge[2]) state_next = Sup;
            else                  state_next = Sdown;
          end else if (bus.free_collision && hit_bottom) begin
            state_next = Sdown;
          end
        end

        Sleft: begin
          if (bus.border_collision && hit_left) state_next = Sbounce_from_left;
          else if (expired)                     state_next = Sidle;
        end

        Sright: begin
          if (bus.border_collision && hit_right) state_next = Sbounce_from_right;
          else if (expired)                      state_next = Sidle;
        end

        Sup: begin
          if (bus.border_collision && hit_top) state_next = Sbounce_from_top;
          else if (expired)                    state_next = Sdown;
        end

        Sbounce_from_left: begin
          if (expired) state_next = Sdown_from_left;
        end

        Sbounce_from_right: begin
          if (expired) state_next = Sdown_from_right;
        end

        Sbounce_from_top: begin
          if (expired) state_next = Sdown;
        end

        Sdown, Sdown_from_left, Sdown_from_right: begin
          if (bus.step_collision && hit_bottom) begin
            state_next = Sidle;
          end else if (bus.free_collision && hit_bottom) begin
            state_next = state_reg;
          end else if (bus.border_collision && hit_bottom) begin
            state_next = Sdie;
          end
        end

        Sdie: begin
          if (expired) begin
            state_next = Sreset;
            if (lives_reg != 2'd0) lives_next = lives_reg - 2'd1;
            if (lives_reg <= 2'd1) game_over_next = 1'b1;
            else                   respawn_next   = 1'b1;
          end
        end

        default: state_next = Sreset;
      endcase
    end
  end

endmodule

// File: tb/tb_bumpy_state_ctrl.sv
// Directed bench for bumpy_state_ctrl: a frame-counting game model runs
// alongside the DUT and is compared every cycle, with literal spot checks.
module tb_bumpy_state_ctrl;
  import bumpy_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bumpy_state_ctrl_if bus ();

  bumpy_state_ctrl #(
    .HOP_FRAMES    (16),
    .UP_FRAMES     (10),
    .BOUNCE_FRAMES (8),
    .DIE_FRAMES    (30),
    .INIT_LIVES    (3)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  // ---------------- game model ----------------
  int         m_state = 0;
  int         m_lives = 3;
  int         m_cnt = 0;
  bit         m_go = 1'b0;
  bit         m_resp = 1'b0;
  logic [3:0] m_keyd = 4'b0;
  int         inj_req = 0;
  int         inj_ack = 0;

  function automatic int lim_of(input int s);
    case (s)
      2, 3:    return 16;
      5:       return 10;
      7, 8, 9: return 8;
      6:       return 30;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] k;
    logic [3:0] e;
    int  s;
    int  nxt;
    bit  hb, hr, ht, hl, ex;
    k = {bus.key_down, bus.key_up, bus.key_right, bus.key_left};
    e = k & ~m_keyd;
    m_keyd = k;
    s = m_state;
    if (inj_req != inj_ack) begin
      s = 13;
      inj_ack = inj_req;
    end
    hb = bus.HitEdgeCode[0];
    hr = bus.HitEdgeCode[1];
    ht = bus.HitEdgeCode[2];
    hl = bus.HitEdgeCode[3];
    ex = bus.startOfFrame && (lim_of(s) != 0) && (m_cnt + 1 == lim_of(s));
    nxt = s;
    if (s > 11) nxt = 0;
    else if (bus.death_collision && s != 0 && s != 6) nxt = 6;
    else begin
      case (s)
        0: begin
          if (bus.game_start) begin
            nxt = 1; m_resp = 1'b0;
            if (m_go) begin m_lives = 3; m_go = 1'b0; end
          end else if (m_resp) begin
            nxt = 1; m_resp = 1'b0;
          end
        end
        1: begin
          if ($countones(e) == 1) begin
            if (e[0]) nxt = 2;
            else if (e[1]) nxt = 3;
            else if (e[2]) nxt = 5;
            else nxt = 4;
          end else if (bus.free_collision && hb) nxt = 4;
        end
        2: if (bus.border_collision && hl) nxt = 7; else if (ex) nxt = 1;
        3: if (bus.border_collision && hr) nxt = 8; else if (ex) nxt = 1;
        5: if (bus.border_collision && ht) nxt = 9; else if (ex) nxt = 4;
        7: if (ex) nxt = 11;
        8: if (ex) nxt = 10;
        9: if (ex) nxt = 4;
        4, 10, 11: begin
          if (bus.step_collision && hb) nxt = 1;
          else if (bus.free_collision && hb) nxt = s;
          else if (bus.border_collision && hb) nxt = 6;
        end
        6: begin
          if (ex) begin
            nxt = 0;
            if (m_lives <= 1) m_go = 1'b1; else m_resp = 1'b1;
            if (m_lives > 0) m_lives = m_lives - 1;
          end
        end
        default: nxt = 0;
      endcase
    end
    if (nxt != s) m_cnt = 0;
    else if (bus.startOfFrame) m_cnt = m_cnt + 1;
    m_state = nxt;
  endtask

  // Model advances on the same edges as the DUT, resets asynchronously.
  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      m_state = 0; m_lives = 3; m_cnt = 0; m_go = 1'b0; m_resp = 1'b0;
      m_keyd = 4'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- checking helpers ----------------
  // Advance one cycle and compare DUT against the model at the falling edge.
  task automatic tick();
    @(negedge clk);
    checks++;
    if (4'(bus.state) !== 4'(m_state) || bus.lives !== 2'(m_lives) ||
        bus.game_over !== m_go) begin
      errors++;
      $display("FAIL model_cmp t=%0t state=%0d req=%0d lives=%0d req=%0d go=%0d req=%0d",
               $time, bus.state, m_state, bus.lives, m_lives, bus.game_over, m_go);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // bit0 left, bit1 right, bit2 up, bit3 down
  task automatic set_keys(input logic [3:0] k);
    bus.key_left  = k[0];
    bus.key_right = k[1];
    bus.key_up    = k[2];
    bus.key_down  = k[3];
  endtask

  task automatic press(input logic [3:0] k);
    set_keys(k);
    tick();
    set_keys(4'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
    end
  endtask

  // kind: 0 step, 1 free, 2 border, 3 death
  task automatic collide(input int kind, input logic [3:0] hit);
    bus.step_collision   = (kind == 0);
    bus.free_collision   = (kind == 1);
    bus.border_collision = (kind == 2);
    bus.death_collision  = (kind == 3);
    bus.HitEdgeCode      = hit;
    tick();
    bus.step_collision   = 1'b0;
    bus.free_collision   = 1'b0;
    bus.border_collision = 1'b0;
    bus.death_collision  = 1'b0;
    bus.HitEdgeCode      = 4'b0;
  endtask

  task automatic start_pulse();
    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.startOfFrame = 1'b0;
    bus.game_start = 1'b0;
    set_keys(4'b0);
    bus.step_collision = 1'b0;
    bus.free_collision = 1'b0;
    bus.border_collision = 1'b0;
    bus.death_collision = 1'b0;
    bus.HitEdgeCode = 4'b0;

    // Reset and start
    idle(3);
    check("reset_state", bus.state, 0);
    check("reset_lives", bus.lives, 3);
    check("reset_game_over", bus.game_over, 0);
    resetN = 1'b1;
    idle(2);
    check("wait_for_start", bus.state, 0);
    start_pulse();
    check("start_to_idle", bus.state, 1);

    // Right hop times out after 16 frames
    press(4'b0010);
    check("right_edge", bus.state, 3);
    frames(15);
    check("hop_frame15", bus.state, 3);
    frames(1);
    check("hop_frame16", bus.state, 1);
    check("model_pin_hop", m_state, 1);

    // Left hop, bounce, fall, land
    press(4'b0001);
    check("left_edge", bus.state, 2);
    collide(2, RIGHT);
    check("left_wrong_edge", bus.state, 2);
    collide(2, LEFT);
    check("bounce_left", bus.state, 7);
    frames(7);
    check("bounce_frame7", bus.state, 7);
    frames(1);
    check("down_from_left", bus.state, 11);
    collide(0, BOTTOM);
    check("land_idle", bus.state, 1);

    // Up: 10th frame and top border together, collision wins
    press(4'b0100);
    check("up_edge", bus.state, 5);
    frames(9);
    check("up_frame9", bus.state, 5);
    bus.startOfFrame = 1'b1;
    bus.border_collision = 1'b1;
    bus.HitEdgeCode = TOP;
    tick();
    bus.startOfFrame = 1'b0;
    bus.border_collision = 1'b0;
    bus.HitEdgeCode = 4'b0;
    check("top_beats_expiry", bus.state, 9);
    frames(8);
    check("bounce_top_to_down", bus.state, 4);
    collide(1, BOTTOM);
    check("free_stays_down", bus.state, 4);
    collide(0, BOTTOM);
    check("down_land", bus.state, 1);

    // Three deaths end the game
    for (int r = 0; r < 3; r++) begin
      press(4'b0010);
      check("die_round_right", bus.state, 3);
      collide(3, 4'b0);
      check("death_enter", bus.state, 6);
      frames(29);
      check("die_frame29", bus.state, 6);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      check("die_to_reset", bus.state, 0);
      check("lives_after_die", bus.lives, 2 - r);
      tick();
      if (r < 2) begin
        check("respawn_idle", bus.state, 1);
      end else begin
        check("game_over_hold", bus.state, 0);
        check("game_over_flag", bus.game_over, 1);
      end
    end
    idle(3);
    check("game_over_stays", bus.state, 0);
    check("model_pin_lives", m_lives, 0);
    start_pulse();
    check("restart_idle", bus.state, 1);
    check("restart_lives", bus.lives, 3);
    check("restart_go_clear", bus.game_over, 0);

    // Two edges in one cycle are ignored
    press(4'b0011);
    check("double_edge_ignored", bus.state, 1);
    press(4'b1000);
    check("down_edge", bus.state, 4);
    collide(0, BOTTOM);
    check("down_land2", bus.state, 1);

    // Illegal code recovers to Sreset
    #2;
    force dut.state_reg = state_t'(4'd13);
    #1;
    release dut.state_reg;
    inj_req++;
    tick();
    check("illegal_to_reset", bus.state, 0);
    idle(2);
    check("illegal_no_autostart", bus.state, 0);
    start_pulse();
    check("illegal_restart", bus.state, 1);

    // Lose a life, then asynchronous reset mid-hop restores everything
    press(4'b0010);
    collide(3, 4'b0);
    frames(30);
    tick();
    check("pre_async_lives", bus.lives, 2);
    press(4'b0001);
    frames(3);
    check("mid_hop", bus.state, 2);
    #2;
    resetN = 1'b0;
    #1;
    check("async_state", bus.state, 0);
    check("async_lives", bus.lives, 3);
    check("async_go", bus.game_over, 0);
    tick();
    resetN = 1'b1;
    idle(2);
    check("after_async", bus.state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bumpy_state_ctrl.md
# bumpy_state_ctrl

Game-control FSM that produces the 4-bit Bumpy motion state consumed by the Bumpy motion/position block. It sits between the keyboard decoder and collision logic on one side and the motion block on the other. It converts key edges, collision pulses and frame ticks into one registered state per cycle, and tracks lives and game-over.

## Interface
Parameters:
- HOP_FRAMES, 16, frames a left/right hop lasts before returning to Sidle
- UP_FRAMES, 10, frames of Sup before forced Sdown
- BOUNCE_FRAMES, 8, frames spent in any Sbounce_* state
- DIE_FRAMES, 30, frames of Sdie animation
- INIT_LIVES, 3, lives loaded on reset and on game_start after game-over (1..3)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
- game_start  in  1  one-cycle pulse; leaves Sreset
- key_left, key_right, key_up, key_down  in  1 each  level key inputs; rising edges act
- step_collision  in  1  Bumpy touches a solid tile
- free_collision  in  1  Bumpy touches an empty (hole) tile
- border_collision  in  1  Bumpy touches screen border
- death_collision  in  1  Bumpy touches a hazard
- HitEdgeCode  in  4  one-hot edge: BOTTOM=0001, RIGHT=0010, TOP=0100, LEFT=1000
- state  out  4  motion state, encoding below
- lives  out  2  remaining lives
- game_over  out  1  high while lives==0 in Sreset

## Operation
- State encoding: Sreset=0, Sidle=1, Sleft=2, Sright=3, Sdown=4, Sup=5, Sdie=6, Sbounce_from_left=7, Sbounce_from_right=8, Sbounce_from_top=9, Sdown_from_right=10, Sdown_from_left=11. The codes 12..15 are illegal and go to Sreset on the next clock.
- Key edges: each key is registered once, and edge = key & ~key_d. If more than one edge occurs in the same cycle, none is acted on.
- The frame timer counts startOfFrame pulses. It clears on every state change, and "expires" means the count reaches the state's limit.
- Transitions (priority top to bottom, evaluated every clock):
  - death_collision in any state except Sreset/Sdie -> Sdie.
  - Sreset: on game_start go to Sidle. If game_over was set, reload lives=INIT_LIVES first.
  - Sidle: left edge -> Sleft, right edge -> Sright, up edge -> Sup, down edge -> Sdown. free_collision&BOTTOM -> Sdown.
  - Sleft: border_collision&LEFT -> Sbounce_from_left. Otherwise, timer expiry at HOP_FRAMES -> Sidle.
  - Sright: border_collision&RIGHT -> Sbounce_from_right. Otherwise, timer expiry at HOP_FRAMES -> Sidle.
  - Sup: border_collision&TOP -> Sbounce_from_top. Otherwise, expiry at UP_FRAMES -> Sdown.
  - Sbounce_from_left: expiry at BOUNCE_FRAMES -> Sdown_from_left.
  - Sbounce_from_right: expiry at BOUNCE_FRAMES -> Sdown_from_right.
  - Sbounce_from_top: expiry at BOUNCE_FRAMES -> Sdown.
  - Sdown, Sdown_from_left, Sdown_from_right: step_collision&BOTTOM -> Sidle. free_collision&BOTTOM stays. border_collision&BOTTOM -> Sdie.
  - Sdie: expiry at DIE_FRAMES -> Sreset and lives decrement (saturating at 0). If lives was already 1, game_over sets. Otherwise Sreset auto-advances to Sidle the next cycle without game_start.
- Collision inputs are ignored unless the HitEdgeCode bit required by the rule is set.

## Timing
- Reset values: state=Sreset, lives=INIT_LIVES, game_over=0, timer=0, key_d=0.
- state is registered. An input seen at clock N appears on state at N+1.
- A key edge needs key low in cycle N-1 and high in cycle N, which gives the state change at N+1.
- Expiry: the transition occurs on the clock edge of the Nth startOfFrame pulse counted in the state. The pulse that coincides with entry is not counted.
- A collision and an expiry in the same cycle: the collision wins.
- Asserting resetN mid-hop returns all outputs to reset values asynchronously.

## Structure
- Shared package bumpy_pkg holds:
  - the state enum typedef (reused by the motion block's state port)
  - the HitEdgeCode constants BOTTOM/RIGHT/TOP/LEFT
- Sub-module bumpy_frame_timer:
  - inputs: clk, resetN, clear, startOfFrame, limit[4:0]
  - output: expired
  - 5-bit count
- The FSM, key edge detection and lives counter live in bumpy_state_ctrl (~200 lines).

## Test plan
- Reset, then game_start pulse -> state 0 then 1 at the next clock. lives=3, game_over=0.
- Sidle, key_right rises -> state=3. After 16 startOfFrame pulses with no collision -> state=1.
- Sleft, border_collision with HitEdgeCode=1000 -> 7. 8 frames later -> 11. step_collision with 0001 -> 1.
- Sup, the same cycle delivers both the 10th frame pulse and border_collision TOP -> 9 (not 4).
- Sright, death_collision -> 6. 30 frames later -> 0, then 1, with lives=2. Repeat twice more -> remains 0, lives=0, game_over=1. game_start -> 1, lives=3.
- Both key_left and key_right rise in the same cycle in Sidle -> state stays 1. Forcing an illegal code 13 -> 0.
